// File: rtl/rdi_ltsm_cmd_arbiter.sv
// Fixed-priority sequencer for RDI-to-LTSM state commands on lclk; one go_to_* level at a time with hold and gap.
// Optional ack timeout (escalating to LinkError) is built when RDI_ARB_TIMEOUT_EN is defined.
module rdi_ltsm_cmd_arbiter #(
  parameter int HOLD_MIN    = 4,
  parameter int GAP_CYC     = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_req,
  input  logic       i_ack,
  output logic       o_go_to_linkerror,
  output logic       o_go_to_reset,
  output logic       o_go_to_l2,
  output logic       o_go_to_l1,
  output logic       o_go_to_retrain,
  output logic       o_go_to_training,
  output logic       o_go_to_active,
  output logic [2:0] o_grant_id,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_abort,
  output logic       o_timeout,
  output logic [6:0] o_pending,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RELEASE  = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam int L_MAX_HG = (HOLD_MIN > GAP_CYC) ? HOLD_MIN : GAP_CYC;
  localparam int L_MAX    = (L_MAX_HG > TIMEOUT_CYC) ? L_MAX_HG : TIMEOUT_CYC;
  localparam logic [CNT_W-1:0] L_CNT_SAT   = CNT_W'(L_MAX);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] L_GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       L_NO_GRANT  = 3'd7;

  state_t           r_state;
  logic [6:0]       r_pending;
  logic [6:0]       r_go;
  logic [2:0]       r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_abort;

  logic [2:0]       w_win_id;
  logic             w_grant_now;
  logic             w_accept;
  logic             w_preempt;
  logic             w_to_hit;
  logic [6:0]       w_clr;
  logic [6:0]       w_set;

  // Lowest set index wins, so linkerror (bit 0) always has top priority.
  always_comb begin
    w_win_id = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (r_pending[k]) w_win_id = 3'(k);
    end
  end

  // Handshake: a go_to_* level and i_ack form a 4-phase pair. The level rises,
  // ack rises once the LTSM reaches the target, the level falls, then ack falls.
  assign w_grant_now = (r_state == S_IDLE) && (|r_pending);
  assign w_accept    = (r_state == S_WAIT_ACK) && i_ack && (r_cnt >= L_HOLD_LAST);
  assign w_preempt   = (r_state == S_WAIT_ACK) && !w_accept && r_pending[0] &&
                       (r_grant != 3'd0);

`ifdef RDI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic r_timeout;
  assign w_to_hit  = (r_state == S_WAIT_ACK) && !w_accept && !w_preempt &&
                     (r_cnt == L_TO_LAST);
  assign w_set     = i_req | {6'b0, w_to_hit};
  assign o_timeout = r_timeout;
`else
  assign w_to_hit  = 1'b0;
  assign w_set     = i_req;
  assign o_timeout = 1'b0;
`endif

  assign w_clr = w_grant_now ? (7'b000_0001 << w_win_id) : 7'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= 7'b0;
      r_go      <= 7'b0;
      r_grant   <= L_NO_GRANT;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
`ifdef RDI_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      // A new request on the bit being cleared wins, so nothing is dropped.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
`ifdef RDI_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grant_now) begin
            r_grant <= w_win_id;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_go    <= 7'b000_0001 << r_grant;
          r_cnt   <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (r_cnt < L_CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          if (w_accept) begin
            r_done  <= 1'b1;
            r_go    <= 7'b0;
            r_state <= S_RELEASE;
          end else if (w_preempt) begin
            r_abort <= 1'b1;
            r_go    <= 7'b0;
            r_state <= S_RELEASE;
          end else if (w_to_hit) begin
`ifdef RDI_ARB_TIMEOUT_EN
            r_timeout <= 1'b1;
`endif
            r_go    <= 7'b0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_go <= 7'b0;
          if (!i_ack) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt >= L_GAP_LAST) begin
            r_grant <= L_NO_GRANT;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_go    <= 7'b0;
          r_grant <= L_NO_GRANT;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_go_to_linkerror = r_go[0];
  assign o_go_to_reset     = r_go[1];
  assign o_go_to_l2        = r_go[2];
  assign o_go_to_l1        = r_go[3];
  assign o_go_to_retrain   = r_go[4];
  assign o_go_to_training  = r_go[5];
  assign o_go_to_active    = r_go[6];
  assign o_grant_id        = r_grant;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
  assign o_abort           = r_abort;
  assign o_pending         = r_pending;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_rdi_ltsm_cmd_arbiter.sv
// Scoreboard bench for rdi_ltsm_cmd_arbiter: directed request/ack scenarios, event queue checked by a monitor.
// Build with +define+RDI_ARB_TIMEOUT_EN to exercise the ack timeout path.
module tb_rdi_ltsm_cmd_arbiter;

  localparam int HOLD_MIN    = 4;
  localparam int GAP_CYC     = 3;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_W       = 11;
  localparam int W           = 14;

  localparam logic [3:0] K_CMD  = 4'd1;
  localparam logic [3:0] K_DONE = 4'd2;
  localparam logic [3:0] K_ABRT = 4'd3;
  localparam logic [3:0] K_TOUT = 4'd4;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_req;
  logic       i_ack;
  logic       o_go_to_linkerror, o_go_to_reset, o_go_to_l2, o_go_to_l1;
  logic       o_go_to_retrain, o_go_to_training, o_go_to_active;
  logic [2:0] o_grant_id;
  logic       o_busy, o_done, o_abort, o_timeout;
  logic [6:0] o_pending;
  logic [2:0] o_dbg_state;

  always #5 i_clk = ~i_clk;

  rdi_ltsm_cmd_arbiter #(
    .HOLD_MIN(HOLD_MIN), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ack(i_ack),
    .o_go_to_linkerror(o_go_to_linkerror), .o_go_to_reset(o_go_to_reset),
    .o_go_to_l2(o_go_to_l2), .o_go_to_l1(o_go_to_l1), .o_go_to_retrain(o_go_to_retrain),
    .o_go_to_training(o_go_to_training), .o_go_to_active(o_go_to_active),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort),
    .o_timeout(o_timeout), .o_pending(o_pending), .o_dbg_state(o_dbg_state)
  );

  logic [6:0] go_vec;
  assign go_vec = {o_go_to_active, o_go_to_training, o_go_to_retrain, o_go_to_l1,
                   o_go_to_l2, o_go_to_reset, o_go_to_linkerror};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [3:0] kind, input logic [2:0] id,
                                      input logic [6:0] go);
    return {kind, id, go};
  endfunction

  task automatic push_cmd(input logic [2:0] id);
    logic [6:0] one;
    one = 7'b000_0001 << id;
    exp_q.push_back(ev(K_CMD, id, one));
  endtask

  task automatic push_ev(input logic [3:0] kind, input logic [2:0] id);
    exp_q.push_back(ev(kind, id, 7'b0));
  endtask

  task automatic sb_event(input logic [W-1:0] act, input string nm);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got event 0x%0h, none expected", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s: got event 0x%0h expected 0x%0h", nm, act, e);
      end
    end
  endtask

  // Monitor: every command start and every done/abort/timeout pulse is an event.
  initial begin
    logic [6:0] prev;
    int low;
    prev = 7'b0;
    low  = 100;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prev = 7'b0;
        low  = 100;
      end else begin
        if (|go_vec) check("onehot", 32'($onehot(go_vec)), 1);
        if ((|go_vec) && !(|prev)) begin
          check("gap_len", 32'(low >= GAP_CYC), 1);
          sb_event(ev(K_CMD, o_grant_id, go_vec), "cmd_event");
        end
        if (o_done)    sb_event(ev(K_DONE, o_grant_id, go_vec), "done_event");
        if (o_abort)   sb_event(ev(K_ABRT, o_grant_id, go_vec), "abort_event");
        if (o_timeout) sb_event(ev(K_TOUT, o_grant_id, go_vec), "timeout_event");
        low  = (|go_vec) ? 0 : low + 1;
        prev = go_vec;
      end
    end
  end

  // ---------------- LTSM ack responder ----------------
  logic ack_en;
  int   ack_dly;

  initial begin
    int hi_cnt;
    hi_cnt = 0;
    i_ack  = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        hi_cnt = 0;
        i_ack  = 1'b0;
      end else if (|go_vec) begin
        hi_cnt++;
        if (ack_en && hi_cnt >= ack_dly) i_ack = 1'b1;
      end else begin
        hi_cnt = 0;
        i_ack  = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req(input logic [6:0] v);
    @(posedge i_clk); #1;
    i_req = v;
    @(posedge i_clk); #1;
    i_req = 7'b0;
  endtask

  task automatic wait_go(input int k, input int max, input string nm);
    int n;
    n = 0;
    while (go_vec[k] !== 1'b1 && n < max) begin
      @(negedge i_clk);
      n++;
    end
    check(nm, 32'(go_vec[k]), 1);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < max) begin
      @(negedge i_clk);
      n++;
    end
    check(nm, 32'(o_busy), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    i_rst_n = 1'b0;
    i_req   = 7'b0;
    ack_en  = 1'b0;
    ack_dly = 2;
    repeat (3) @(negedge i_clk);
    check("rst_go", 32'(go_vec), 0);
    check("rst_grant", 32'(o_grant_id), 7);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_pulses", 32'({o_done, o_abort, o_timeout}), 0);
    check("rst_pending", 32'(o_pending), 0);
    check("rst_state", 32'(o_dbg_state), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // T1: single L1 with ack 2 cycles after the level
    ack_en = 1'b1;
    push_cmd(3'd3);
    push_ev(K_DONE, 3'd3);
    pulse_req(7'h08);
    @(negedge i_clk);
    check("t1_pending", 32'(o_pending), 32'h08);
    n = 1;
    while (!o_go_to_l1 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    check("t1_latency", n, 3);
    check("t1_grant", 32'(o_grant_id), 3);
    n = 0;
    while (o_go_to_l1 && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    check("t1_hold", n, HOLD_MIN);
    check("t1_done", 32'(o_done), 1);
    n = 0;
    while (o_busy && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("t1_release_gap", n, 1 + GAP_CYC);
    check("t1_idle_grant", 32'(o_grant_id), 7);
    check("t1_idle_pending", 32'(o_pending), 0);

    // T2: l2 and active in one cycle, l2 first
    push_cmd(3'd2);
    push_ev(K_DONE, 3'd2);
    push_cmd(3'd6);
    push_ev(K_DONE, 3'd6);
    pulse_req(7'h44);
    @(negedge i_clk);
    check("t2_pending", 32'(o_pending), 32'h44);
    wait_go(2, 20, "t2_l2_issued");
    wait_go(6, 100, "t2_active_issued");
    wait_idle(100, "t2_idle");
    check("t2_pending_end", 32'(o_pending), 0);

    // T3: linkerror preempts an unacked L1
    ack_en = 1'b0;
    push_cmd(3'd3);
    push_ev(K_ABRT, 3'd3);
    push_cmd(3'd0);
    push_ev(K_DONE, 3'd0);
    pulse_req(7'h08);
    wait_go(3, 20, "t3_l1_issued");
    repeat (2) @(negedge i_clk);
    pulse_req(7'h01);
    @(negedge i_clk);
    check("t3_l1_before_abort", 32'(o_go_to_l1), 1);
    @(negedge i_clk);
    check("t3_abort", 32'(o_abort), 1);
    check("t3_l1_low", 32'(o_go_to_l1), 0);
    check("t3_no_repend", 32'(o_pending), 32'h01);
    n = 0;
    while (!o_go_to_linkerror && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("t3_le_delay", n, 1 + GAP_CYC + 2);
    check("t3_le_pending", 32'(o_pending), 0);
    ack_en = 1'b1;
    wait_idle(50, "t3_idle");

    // T4: retrain with ack held low
    ack_en = 1'b0;
    push_cmd(3'd4);
    pulse_req(7'h10);
    wait_go(4, 20, "t4_retrain_issued");
`ifdef RDI_ARB_TIMEOUT_EN
    push_ev(K_TOUT, 3'd4);
    push_cmd(3'd0);
    push_ev(K_DONE, 3'd0);
    n = 0;
    while (!o_timeout && n < TIMEOUT_CYC + 50) begin
      @(negedge i_clk);
      n++;
    end
    check("t4_timeout_at", n, TIMEOUT_CYC);
    check("t4_retrain_low", 32'(o_go_to_retrain), 0);
    check("t4_le_pended", 32'(o_pending), 32'h01);
    wait_go(0, 20, "t4_le_issued");
    ack_en = 1'b1;
    wait_idle(50, "t4_idle");
`else
    n = 0;
    while (o_go_to_retrain && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check("t4_no_timeout_hold", n, 2000);
    check("t4_no_timeout_pulse", 32'(o_timeout), 0);
    push_ev(K_DONE, 3'd4);
    ack_en = 1'b1;
    wait_idle(50, "t4_idle");
`endif

    // T5: async reset while l2 is asserted and active is pending
    ack_en = 1'b0;
    push_cmd(3'd2);
    pulse_req(7'h04);
    wait_go(2, 20, "t5_l2_issued");
    pulse_req(7'h40);
    @(negedge i_clk);
    check("t5_pending_before", 32'(o_pending), 32'h40);
    check("t5_l2_before", 32'(o_go_to_l2), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_rst_go", 32'(go_vec), 0);
    check("t5_rst_grant", 32'(o_grant_id), 7);
    check("t5_rst_busy", 32'(o_busy), 0);
    check("t5_rst_pulses", 32'({o_done, o_abort, o_timeout}), 0);
    check("t5_rst_pending", 32'(o_pending), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    ack_en  = 1'b1;
    repeat (10) @(negedge i_clk);
    check("t5_after_busy", 32'(o_busy), 0);
    check("t5_after_pending", 32'(o_pending), 0);

    // T6: same request during the in-flight command re-issues it
    push_cmd(3'd3);
    push_ev(K_DONE, 3'd3);
    push_cmd(3'd3);
    push_ev(K_DONE, 3'd3);
    pulse_req(7'h08);
    wait_go(3, 20, "t6_l1_issued");
    pulse_req(7'h08);
    @(negedge i_clk);
    check("t6_repend", 32'(o_pending), 32'h08);
    check("t6_l1_inflight", 32'(o_go_to_l1), 1);
    n = 0;
    while (o_go_to_l1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    wait_go(3, 30, "t6_l1_reissued");
    wait_idle(50, "t6_idle");

    repeat (5) @(negedge i_clk);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
